// File: rtl/aes_pkg.sv
// Shared definitions for the parametrised AES/Rijndael round blocks:
// mode encoding, legal state widths and ShiftRows row offsets.
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael widens the row 2/3 offsets only for the 256-bit state.
  function automatic int row_offset(input int nb, input int r);
    if ((nb == 8) && (r >= 2)) return r + 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation over an NB-column state.
// Pure wiring: every output byte is a 2:1 mux between two fixed input bytes.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic            mode,
  input  logic [32*NB-1:0] state,
  output logic [32*NB-1:0] shifted
);

  if (!nb_legal(NB)) begin : g_nb_check
    $error("shift_rows_perm: NB must be 4, 6 or 8");
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int CR    = row_offset(NB, r);
      localparam int FWD_C = (c + CR) % NB;
      localparam int INV_C = (c + NB - CR) % NB;
      assign shifted[r*NB*8 + 8*c +: 8] = (mode == MODE_INV)
                                          ? state[r*NB*8 + 8*INV_C +: 8]
                                          : state[r*NB*8 + 8*FWD_C +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Two-stage valid/ready pipeline around the ShiftRows permutation.
// S1 captures the raw input, S2 captures the permuted state; full throughput, lossless stall.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [32*NB-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [32*NB-1:0] out_data
);

  localparam int W = 32 * NB;

  if (!nb_legal(NB)) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic         s1_valid;
  logic         s1_mode;
  logic [W-1:0] s1_data;
  logic         s2_valid;
  logic         s2_mode;
  logic [W-1:0] s2_data;
  logic [W-1:0] perm_data;
  logic         s1_load;
  logic         s2_load;

  // S2 may refill in the same cycle it drains, so in_ready sees out_ready directly.
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  shift_rows_perm #(
    .NB(NB)
  ) u_perm (
    .mode    (s1_mode),
    .state   (s1_data),
    .shifted (perm_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_FWD;
      s1_data  <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_mode  <= in_mode;
      s1_data  <= in_data;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Data and mode only change on a load, which keeps them stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= MODE_FWD;
      s2_data  <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_mode  <= s1_mode;
      s2_data  <= perm_data;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out_mode  = s2_mode;
  assign out_data  = s2_data;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 and NB=8 instances, directed vectors,
// expected states pushed at acceptance and popped by per-instance output monitors.
module tb_shift_rows_pipe;
  import aes_pkg::*;

  typedef struct packed {
    logic         mode;
    logic [255:0] data;
  } exp_t;

  // Hand-computed vectors: byte (r,c) = 4r+c (NB=4) or 8r+c (NB=8).
  localparam logic [127:0] IN4   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] EXP4F = 128'h0E0D0C0F_09080B0A_04070605_03020100;
  localparam logic [127:0] EXP4I = 128'h0C0F0E0D_09080B0A_06050407_03020100;
  localparam logic [255:0] IN8   = 256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
  localparam logic [255:0] EXP8F = 256'h1B1A19181F1E1D1C_1211101716151413_080F0E0D0C0B0A09_0706050403020100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_mode4;
  logic [127:0] in_data4, out_data4;
  logic         in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_mode8;
  logic [255:0] in_data8, out_data8;

  exp_t sb4[$];
  exp_t sb8[$];
  int   pops4[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_mode(in_mode4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_mode(out_mode4), .out_data(out_data4)
  );

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_mode(in_mode8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_mode(out_mode8), .out_data(out_data8)
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Byte (r,c) = base + 16r + c.
  function automatic logic [255:0] pattern(input int nb, input logic [7:0] base);
    logic [255:0] p = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        p[r*nb*8 + 8*c +: 8] = base + 8'(16*r + c);
    return p;
  endfunction

  // Reference: each row treated as a word and rotated by whole bytes.
  function automatic logic [255:0] model(input int nb, input logic mode, input logic [255:0] din);
    int           offs[4];
    logic [255:0] mask, row, rot, res;
    offs = (nb == 8) ? '{0, 1, 3, 4} : '{0, 1, 2, 3};
    mask = (256'd1 << (nb*8)) - 256'd1;
    res  = '0;
    for (int r = 0; r < 4; r++) begin
      row = (din >> (r*nb*8)) & mask;
      if (mode == MODE_FWD)
        rot = ((row >> (8*offs[r])) | (row << (8*(nb - offs[r])))) & mask;
      else
        rot = ((row << (8*offs[r])) | (row >> (8*(nb - offs[r])))) & mask;
      res |= rot << (r*nb*8);
    end
    return res;
  endfunction

  task automatic applyStimulus(input int nb, input logic mode, input logic [255:0] data,
                               input logic [255:0] expected, output int waited);
    exp_t e;
    bit   accepted = 0;
    e.mode = mode;
    e.data = expected;
    waited = 0;
    if (nb == 8) begin
      in_valid8 = 1'b1; in_mode8 = mode; in_data8 = data;
    end else begin
      in_valid4 = 1'b1; in_mode4 = mode; in_data4 = data[127:0];
    end
    while (!accepted && waited < 20) begin
      @(negedge clk);
      if ((nb == 8) ? in_ready8 : in_ready4) accepted = 1;
      else begin
        waited++;
        @(posedge clk);
      end
    end
    if (accepted) begin
      if (nb == 8) sb8.push_back(e);
      else sb4.push_back(e);
      @(posedge clk);
    end else begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout nb=%0d: in_ready low for %0d cycles, required acceptance", nb, waited);
    end
    #1;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb4.size() != 0 || sb8.size() != 0) && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (sb4.size() != 0 || sb8.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d/%0d outstanding, required 0", sb4.size(), sb8.size());
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid4 && out_ready4) begin
      if (sb4.size() == 0) checkOutput("dut4_unexpected_output", 256'(out_valid4), 256'd0);
      else begin
        e = sb4.pop_front();
        checkOutput("dut4_mode", 256'(out_mode4), 256'(e.mode));
        checkOutput("dut4_data", 256'(out_data4), e.data);
        pops4.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) checkOutput("dut8_unexpected_output", 256'(out_valid8), 256'd0);
      else begin
        e = sb8.pop_front();
        checkOutput("dut8_mode", 256'(out_mode8), 256'(e.mode));
        checkOutput("dut8_data", out_data8, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int           w;
    logic [255:0] a, b, c, hold;
    in_valid4 = 0; in_mode4 = 0; in_data4 = '0; out_ready4 = 1;
    in_valid8 = 0; in_mode8 = 0; in_data8 = '0; out_ready8 = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    @(negedge clk);
    checkOutput("reset_out_valid4", 256'(out_valid4), 256'd0);
    checkOutput("reset_in_ready4", 256'(in_ready4), 256'd1);
    checkOutput("reset_out_data4", 256'(out_data4), 256'd0);
    checkOutput("reset_out_mode4", 256'(out_mode4), 256'd0);
    checkOutput("reset_out_valid8", 256'(out_valid8), 256'd0);
    checkOutput("reset_in_ready8", 256'(in_ready8), 256'd1);
    @(posedge clk); #1;

    $display("[TB] forward NB=4 and latency");
    applyStimulus(4, MODE_FWD, 256'(IN4), 256'(EXP4F), w);
    checkOutput("t1_accept_wait", 256'(w), 256'd0);
    @(negedge clk);
    checkOutput("t1_valid_after_accept_edge", 256'(out_valid4), 256'd0);
    @(negedge clk);
    checkOutput("t1_valid_after_next_edge", 256'(out_valid4), 256'd1);
    checkOutput("t1_byte_r1c0", 256'(out_data4[39:32]), 256'h05);
    @(posedge clk); #1;
    waitDrain();

    $display("[TB] inverse NB=4 and round trip");
    applyStimulus(4, MODE_INV, 256'(IN4), 256'(EXP4I), w);
    applyStimulus(4, MODE_INV, 256'(EXP4F), 256'(IN4), w);
    a = pattern(4, 8'h30);
    applyStimulus(4, MODE_INV, a, model(4, MODE_INV, a), w);
    waitDrain();

    $display("[TB] NB=8 forward and inverse");
    applyStimulus(8, MODE_FWD, IN8, EXP8F, w);
    applyStimulus(8, MODE_INV, EXP8F, IN8, w);
    a = pattern(8, 8'h60);
    applyStimulus(8, MODE_INV, a, model(8, MODE_INV, a), w);
    waitDrain();

    $display("[TB] backpressure");
    out_ready4 = 0;
    a = pattern(4, 8'h40); b = pattern(4, 8'h50); c = pattern(4, 8'h70);
    applyStimulus(4, MODE_FWD, a, model(4, MODE_FWD, a), w);
    checkOutput("t4_accept_a", 256'(w), 256'd0);
    applyStimulus(4, MODE_INV, b, model(4, MODE_INV, b), w);
    checkOutput("t4_accept_b", 256'(w), 256'd0);
    hold = model(4, MODE_FWD, a);
    in_valid4 = 1; in_mode4 = MODE_FWD; in_data4 = c[127:0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_in_ready_full", 256'(in_ready4), 256'd0);
      checkOutput("t4_out_valid_held", 256'(out_valid4), 256'd1);
      checkOutput("t4_out_data_held", 256'(out_data4), hold);
      checkOutput("t4_out_mode_held", 256'(out_mode4), 256'(MODE_FWD));
      @(posedge clk); #1;
    end
    out_ready4 = 1;
    @(negedge clk);
    checkOutput("t4_in_ready_released", 256'(in_ready4), 256'd1);
    if (in_ready4) sb4.push_back('{mode: MODE_FWD, data: model(4, MODE_FWD, c)});
    @(posedge clk); #1;
    in_valid4 = 0;
    waitDrain();
    checkOutput("t4_abc_consecutive", 256'(pops4[$] - pops4[$-2]), 256'd2);

    $display("[TB] mixed modes at full rate");
    for (int i = 0; i < 8; i++) begin
      a = pattern(4, 8'(8'h80 + 8'(i*5)));
      applyStimulus(4, logic'(i % 2), a, model(4, logic'(i % 2), a), w);
      checkOutput("t5_accept_no_stall", 256'(w), 256'd0);
    end
    waitDrain();
    checkOutput("t5_one_per_cycle", 256'(pops4[$] - pops4[$-7]), 256'd7);

    $display("[TB] reset mid-stream");
    out_ready4 = 0;
    a = pattern(4, 8'hA0); b = pattern(4, 8'hB0);
    applyStimulus(4, MODE_INV, a, model(4, MODE_INV, a), w);
    applyStimulus(4, MODE_INV, b, model(4, MODE_INV, b), w);
    in_valid4 = 1; in_mode4 = MODE_INV; in_data4 = IN4;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    in_valid4 = 0;
    sb4.delete();
    @(negedge clk);
    checkOutput("t6_out_valid", 256'(out_valid4), 256'd0);
    checkOutput("t6_out_data", 256'(out_data4), 256'd0);
    checkOutput("t6_out_mode", 256'(out_mode4), 256'd0);
    checkOutput("t6_in_ready", 256'(in_ready4), 256'd1);
    @(posedge clk); #1;
    out_ready4 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_no_stale", 256'(out_valid4), 256'd0);
    end
    @(posedge clk); #1;
    applyStimulus(4, MODE_FWD, 256'(IN4), 256'(EXP4F), w);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
